// File: rtl/pitch_game_pkg.sv
// Shared types and screen constants for the pitch game pipeline.
// The renderer imports the same bounds so sprite placement stays consistent.
package pitch_game_pkg;

  typedef logic [9:0] height_t;

  typedef enum logic [2:0] {
    StIdle,
    StMed,
    StEma,
    StTgt,
    StOut
  } tracker_state_t;

  localparam int unsigned ScreenYFloor = 440;
  localparam int unsigned ScreenYCeil  = 40;

endpackage

// File: rtl/player_y_tracker_if.sv
// Frame-rate link between the pitch detector side and the player Y tracker.
interface player_y_tracker_if;
  import pitch_game_pkg::*;

  height_t height;
  logic    frame_tick;
  height_t player_y;
  logic    y_valid;

  modport master (
    output height,
    output frame_tick,
    input  player_y,
    input  y_valid
  );

  modport slave (
    input  height,
    input  frame_tick,
    output player_y,
    output y_valid
  );

endinterface

// File: rtl/median3.sv
// Combinational median of three unsigned 10-bit values.
module median3
  import pitch_game_pkg::*;
(
  input  height_t a_i,
  input  height_t b_i,
  input  height_t c_i,
  output height_t med_o
);

  height_t lo, hi;

  always_comb begin
    lo = (a_i < b_i) ? a_i : b_i;
    hi = (a_i < b_i) ? b_i : a_i;
    // Median is c unless c falls outside [lo, hi]
    if (c_i >= hi) begin
      med_o = hi;
    end else if (c_i <= lo) begin
      med_o = lo;
    end else begin
      med_o = c_i;
    end
  end

endmodule

// File: rtl/player_y_tracker.sv
// Per-frame pitch height to on-screen player Y: median, EMA, map, clamp, rate limit,
// with a gravity fall toward the floor during sustained silence.
module player_y_tracker
  import pitch_game_pkg::*;
#(
  parameter int unsigned Y_FLOOR     = ScreenYFloor,
  parameter int unsigned Y_CEIL      = ScreenYCeil,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned EMA_SHIFT   = 2,
  parameter int unsigned MAX_STEP    = 8,
  parameter int unsigned HOLD_FRAMES = 4,
  parameter int unsigned FALL_STEP   = 4
) (
  input logic               clk,
  input logic               reset,
  player_y_tracker_if.slave bus
);

  localparam logic signed [11:0] FloorS = 12'(Y_FLOOR);
  localparam logic signed [11:0] CeilS  = 12'(Y_CEIL);
  localparam logic signed [11:0] StepS  = 12'(MAX_STEP);
  localparam logic signed [11:0] FallS  = 12'(FALL_STEP);
  localparam logic [7:0]         HoldCnt = 8'(HOLD_FRAMES);

  tracker_state_t state_q, state_d;
  height_t h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
  height_t med_q, med_d, med_w;
  height_t ema_q, ema_d;
  height_t tgt_q, tgt_d;
  height_t y_q, y_d;
  logic [7:0] sil_q, sil_d;
  logic valid_q, valid_d;

  logic signed [10:0] ema_diff, ema_step;
  logic signed [11:0] tgt_raw, mv;

  median3 u_median3 (
    .a_i  (h0_q),
    .b_i  (h1_q),
    .c_i  (h2_q),
    .med_o(med_w)
  );

  always_comb begin
    state_d  = state_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    h2_d     = h2_q;
    med_d    = med_q;
    ema_d    = ema_q;
    tgt_d    = tgt_q;
    y_d      = y_q;
    sil_d    = sil_q;
    valid_d  = 1'b0;
    ema_diff = $signed({1'b0, med_q}) - $signed({1'b0, ema_q});
    ema_step = ema_diff >>> EMA_SHIFT;
    tgt_raw  = '0;
    mv       = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick) begin
          h0_d = bus.height;
          h1_d = h0_q;
          h2_d = h1_q;
          if (bus.height != '0) begin
            sil_d = '0;
          end else if (sil_q != HoldCnt) begin
            sil_d = sil_q + 8'd1;
          end
          state_d = StMed;
        end
      end
      StMed: begin
        med_d   = med_w;
        state_d = StEma;
      end
      StEma: begin
        // Modular add of the signed step; the result always lies between ema and med
        ema_d   = 10'(ema_q + ema_step);
        state_d = StTgt;
      end
      StTgt: begin
        if (sil_q == HoldCnt) begin
          tgt_raw = $signed({2'b00, y_q}) + FallS;
        end else begin
          tgt_raw = FloorS - $signed({2'b00, ema_q >> SCALE_SHIFT});
        end
        if (tgt_raw < CeilS) begin
          tgt_d = 10'(Y_CEIL);
        end else if (tgt_raw > FloorS) begin
          tgt_d = 10'(Y_FLOOR);
        end else begin
          tgt_d = tgt_raw[9:0];
        end
        state_d = StOut;
      end
      StOut: begin
        mv = $signed({2'b00, tgt_q}) - $signed({2'b00, y_q});
        if (mv > StepS) begin
          y_d = y_q + 10'(MAX_STEP);
        end else if (mv < -StepS) begin
          y_d = y_q - 10'(MAX_STEP);
        end else begin
          y_d = tgt_q;
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      med_q   <= '0;
      ema_q   <= '0;
      tgt_q   <= 10'(Y_FLOOR);
      y_q     <= 10'(Y_FLOOR);
      sil_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      med_q   <= med_d;
      ema_q   <= ema_d;
      tgt_q   <= tgt_d;
      y_q     <= y_d;
      sil_q   <= sil_d;
      valid_q <= valid_d;
    end
  end

  assign bus.player_y = y_q;
  assign bus.y_valid  = valid_q;

endmodule

// File: tb/tb_player_y_tracker.sv
// Randomized bench for player_y_tracker against a frame-level arithmetic model.
module tb_player_y_tracker;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  player_y_tracker_if bus ();

  player_y_tracker dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference state
  int m_h0, m_h1, m_h2, m_ema, m_sil, m_y;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int median_of3(input int a, input int b, input int c);
    int v[3];
    int t;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return v[1];
  endfunction

  function automatic int floor_div(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_h0 = 0; m_h1 = 0; m_h2 = 0; m_ema = 0; m_sil = 0; m_y = 440;
  endtask

  task automatic model_frame(input int h);
    int med, tgt, step;
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = h;
    if (h == 0) m_sil = (m_sil < 4) ? m_sil + 1 : 4;
    else m_sil = 0;
    med = median_of3(m_h0, m_h1, m_h2);
    m_ema = m_ema + floor_div(med - m_ema, 4);
    if (m_sil == 4) tgt = m_y + 4;
    else tgt = 440 - m_ema / 2;
    if (tgt < 40) tgt = 40;
    if (tgt > 440) tgt = 440;
    step = tgt - m_y;
    if (step > 8) step = 8;
    if (step < -8) step = -8;
    m_y = m_y + step;
  endtask

  task automatic do_frame(input int h, input bit collide);
    int prev_y;
    prev_y = m_y;
    @(negedge clk);
    bus.height     = 10'(h);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.height     = 10'($urandom_range(1023, 0));
    model_frame(h);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("valid_early", int'(bus.y_valid), 0);
      check("y_hold", int'(bus.player_y), prev_y);
      if (collide && k == 1) begin
        bus.frame_tick = 1'b1;
        bus.height     = 10'($urandom_range(1023, 1));
      end else if (k == 2) begin
        bus.frame_tick = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("valid_pulse", int'(bus.y_valid), 1);
    check("player_y", int'(bus.player_y), m_y);
    @(posedge clk);
    #1;
    check("valid_drop", int'(bus.y_valid), 0);
    check("y_after", int'(bus.player_y), m_y);
    repeat (6) @(posedge clk);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    bus.height     = 10'd500;
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_y", int'(bus.player_y), 440);
    check("rst_async_valid", int'(bus.y_valid), 0);
    model_reset();
    // Tick coincident with reset must be ignored
    @(negedge clk);
    bus.height     = 10'd700;
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    check("rst_tick_y", int'(bus.player_y), 440);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("rst_no_valid", int'(bus.y_valid), 0);
      check("rst_y", int'(bus.player_y), 440);
    end
  endtask

  initial begin
    int r, h;
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.height     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", int'(bus.player_y), 440);
    check("reset_valid", int'(bus.y_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 40; i++) do_frame(400, 1'b0);
    for (int i = 0; i < 30; i++) do_frame(200, 1'b0);
    do_frame(1000, 1'b0);
    for (int i = 0; i < 10; i++) do_frame(200, 1'b0);
    for (int i = 0; i < 80; i++) do_frame(1023, 1'b0);
    for (int i = 0; i < 40; i++) do_frame(400, 1'b0);
    for (int i = 0; i < 60; i++) do_frame(0, 1'b0);
    for (int i = 0; i < 3; i++) do_frame(300, 1'b0);
    for (int i = 0; i < 10; i++) do_frame(0, 1'b0);
    for (int i = 0; i < 6; i++) do_frame(int'($urandom_range(1023, 1)), 1'b1);

    mid_reset();
    for (int i = 0; i < 10; i++) do_frame(int'($urandom_range(1023, 0)), 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(9, 0));
      if (r < 3) h = 0;
      else if (r < 4) h = 1023;
      else h = int'($urandom_range(1023, 1));
      do_frame(h, (r == 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
